irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have reset  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have src  input  6  raw device interrupt lines, asynchronous to clk.
REQ-004 SHALL have addr  input  2  register word select (byte address bits [3:2]).
REQ-005 SHALL have we  input  1  bus write strobe, one write per cycle it is high.
REQ-006 SHALL have wdata  input  32  bus write data.
REQ-007 SHALL have rdata  output  32  bus read data, combinational from addr.
REQ-008 SHALL have hwint  output  6  registered interrupt lines to CP0 HWInt.
REQ-009 SHALL have irq_any  output  1  registered OR of hwint.

Function
REQ-010 SHALL pass each src bit through a 2-flop synchronizer (s1, s2) and keep a third flop s3 = previous s2.
REQ-011 SHALL define register map: addr 0 PEND (RO), 1 MASK (RW), 2 ACK (WO, reads 0), 3 ID (RO).
REQ-012 SHALL compute level-source pending bit = s2 (not latched; ACK has no effect).
REQ-013 SHALL compute masked = pending & MASK[5:0] every cycle.
REQ-014 SHALL register hwint <= masked and irq_any <= |masked each clock.
REQ-015 SHALL give level latency: src high before edge N -> hwint high after edge N+2 (mask set).
REQ-016 SHALL read PEND as {26'b0, pending[5:0]}; MASK as {18'b0, TRIG[5:0], 2'b0, MASK[5:0]}.
REQ-017 SHALL read ID as {valid, 27'b0, 1'b0, idx[2:0]}; idx = lowest set index of masked; valid=|masked; idx=0 when none.
REQ-018 SHALL ignore writes to addr 0 and addr 3; write to addr 1 updates MASK[5:0] from wdata[5:0].
REQ-019 SHALL treat write to addr 2 as write-1-to-clear on latched (edge) pending bits wdata[5:0].
REQ-020 SHALL, when an edge-set and an ACK-clear of the same bit coincide, keep the bit set (set wins).
REQ-021 SHALL update MASK in the same cycle as the write; hwint reflects new mask one edge later.

Reset
REQ-022 SHALL on reset clear s1, s2, s3, MASK, TRIG, latched pending, hwint, irq_any to 0 immediately.
REQ-023 SHALL drive rdata per REQ-016/017 from reset state (all reads 0) while reset held.
REQ-024 SHALL, on reset deassertion mid-pulse of src, resynchronize from scratch with no spurious edge latched (s3 starts 0 but s2 starts 0 too).

Configuration
REQ-025 SHALL honor macro IRQ_CTRL_EDGE_EN.
REQ-026 SHALL with IRQ_CTRL_EDGE_EN: MASK write also loads TRIG[5:0] from wdata[13:8]; TRIG bit 1 = edge mode for that source.
REQ-027 SHALL in edge mode set latched pending on s2 & ~s3 (rising edge), hold until ACK; PEND shows latched bit; latency src rise -> hwint = 4 edges.
REQ-028 SHALL on TRIG bit change 1->0 clear that latched pending bit.
REQ-029 SHALL without IRQ_CTRL_EDGE_EN: no TRIG/latched state, TRIG reads 0, wdata[13:8] ignored, ACK writes have no effect, all sources level.

Verification
REQ-030 SHALL cover: MASK=0x3F, src=6'b000100 held -> hwint=0x04 three edges later, ID=0x80000002, irq_any=1.
REQ-031 SHALL cover: src=0x21, MASK=0x20 -> hwint=0x20, ID=0x80000005; MASK->0x21 -> ID=0x80000000.
REQ-032 SHALL cover: MASK=0 with src=0x3F -> hwint=0, PEND=0x3F, ID=0x00000000.
REQ-033 SHALL cover (EDGE_EN): MASK write 0x0000_0101, 1-cycle pulse on src[0] -> PEND=0x01 held, hwint[0]=1; ACK write 0x01 -> PEND=0, hwint[0]=0 next edge.
REQ-034 SHALL cover (EDGE_EN): ACK of bit 0 in same cycle as new rising edge on src[0] -> PEND bit 0 stays 1.
REQ-035 SHALL cover: reset asserted asynchronously while hwint=0x04 -> hwint=0, MASK read 0 before next clk edge.

Source files
------------

// File: rtl/irq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : irq_ctrl_if                                                  |
// | Description : Register bus bundle for the interrupt controller.            |
// |               master drives addr/we/wdata and samples rdata; slave is the  |
// |               register block.                                              |
// |   addr  [1:0]  register word select (byte address bits [3:2])              |
// |   we           write strobe, one write per cycle it is high                |
// |   wdata [31:0] write data                                                  |
// |   rdata [31:0] read data, combinational from addr                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface irq_ctrl_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output we, output wdata, input rdata);
  modport slave  (input addr, input we, input wdata, output rdata);
endinterface
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : irq_ctrl                                                     |
// | Description : Six-source interrupt controller feeding CP0 HWInt.           |
// |               Sources are synchronised (s1, s2) with a history flop (s3),  |
// |               masked, and registered onto hwint / irq_any. Registers:      |
// |               0 PEND (RO), 1 MASK (RW), 2 ACK (WO, W1C), 3 ID (RO).        |
// |   clk          system clock, rising edge                                   |
// |   reset        asynchronous, active-high reset                             |
// |   src   [5:0]  raw device interrupt lines, asynchronous to clk             |
// |   bus          irq_ctrl_if.slave register port (addr/we/wdata/rdata)       |
// |   hwint [5:0]  registered masked pending lines                             |
// |   irq_any      registered OR of the masked pending lines                   |
// | Build macro : IRQ_CTRL_EDGE_EN - adds per-source TRIG bits (MASK[13:8])    |
// |               selecting rising-edge latched mode, cleared through ACK.     |
// |               Without it every source is level and ACK does nothing.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module irq_ctrl (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic [5:0] src,
  irq_ctrl_if.slave       bus,
  output logic      [5:0] hwint,
  output logic            irq_any
);

  localparam logic [1:0] C_ADDR_PEND = 2'd0;
  localparam logic [1:0] C_ADDR_MASK = 2'd1;
  localparam logic [1:0] C_ADDR_ACK  = 2'd2;
  localparam logic [1:0] C_ADDR_ID   = 2'd3;

  logic [5:0]  s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [5:0]  mask_q, mask_d;
  logic [5:0]  hwint_q, hwint_d;
  logic        irq_any_q, irq_any_d;
  logic        mask_wr, ack_wr;
  logic [5:0]  pending, masked, trig_rd;
  logic [2:0]  idx;
  logic [31:0] rdata;

  // Synchroniser chain and MASK register next state.
  always_comb begin
    mask_wr = bus.we && (bus.addr == C_ADDR_MASK);
    ack_wr  = bus.we && (bus.addr == C_ADDR_ACK);
    s1_d    = src;
    s2_d    = s1_q;
    s3_d    = s2_q;
    mask_d  = mask_wr ? bus.wdata[5:0] : mask_q;
  end

`ifdef IRQ_CTRL_EDGE_EN
  logic [5:0] trig_q, trig_d, lat_q, lat_d;
  logic [5:0] rise, trig_fall, ack_clr;

  // A new rising edge beats a coincident ACK for the same bit; leaving edge
  // mode drops whatever was latched so a stale edge cannot resurface later.
  always_comb begin
    trig_d    = mask_wr ? bus.wdata[13:8] : trig_q;
    rise      = s2_q & ~s3_q;
    trig_fall = trig_q & ~trig_d;
    ack_clr   = ack_wr ? bus.wdata[5:0] : 6'b0;
    lat_d     = ((lat_q & ~ack_clr) | (trig_q & rise)) & ~trig_fall;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_q <= 6'b0;
      lat_q  <= 6'b0;
    end else begin
      trig_q <= trig_d;
      lat_q  <= lat_d;
    end
  end

  assign pending = (trig_q & lat_q) | (~trig_q & s2_q);
  assign trig_rd = trig_q;

  logic unused_wdata;
  assign unused_wdata = &{1'b0, bus.wdata[31:14], bus.wdata[7:6]};
`else
  // Level-only build: s3 is kept for a uniform synchroniser but has no reader.
  assign pending = s2_q;
  assign trig_rd = 6'b0;

  logic unused_level;
  assign unused_level = &{1'b0, bus.wdata[31:6], s3_q, ack_wr};
`endif

  // Masking and lowest-index-wins encoder for the ID register.
  always_comb begin
    masked    = pending & mask_q;
    hwint_d   = masked;
    irq_any_d = |masked;
    idx       = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (masked[i]) idx = 3'(i);
    end
  end

  always_comb begin
    case (bus.addr)
      C_ADDR_PEND: rdata = {26'b0, pending};
      C_ADDR_MASK: rdata = {18'b0, trig_rd, 2'b0, mask_q};
      C_ADDR_ID:   rdata = {|masked, 27'b0, 1'b0, idx};
      default:     rdata = 32'b0;
    endcase
  end

  assign bus.rdata = rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q      <= 6'b0;
      s2_q      <= 6'b0;
      s3_q      <= 6'b0;
      mask_q    <= 6'b0;
      hwint_q   <= 6'b0;
      irq_any_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      mask_q    <= mask_d;
      hwint_q   <= hwint_d;
      irq_any_q <= irq_any_d;
    end
  end

  assign hwint   = hwint_q;
  assign irq_any = irq_any_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_irq_ctrl                                                  |
// | Description : Self-checking bench for irq_ctrl. Expected hwint values are  |
// |               queued with the cycle they are due and compared as the       |
// |               cycles elapse; register reads are compared inline.           |
// |               Edge-mode scenarios exist only when IRQ_CTRL_EDGE_EN is set. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] src;
  logic [5:0] hwint;
  logic       irq_any;

  irq_ctrl_if bus();

  irq_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .src     (src),
    .bus     (bus),
    .hwint   (hwint),
    .irq_any (irq_any)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         due;
    logic [5:0] hw;
    string      tag;
  } exp_t;

  exp_t sb[$];

  task automatic expect_hw(input int due, input logic [5:0] hw, input string tag);
    exp_t e;
    e.due = due;
    e.hw  = hw;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic bus_start(input logic [1:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_start(a, d);
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic test_reset;
    exp_t none;
    none.hw = 6'h00;
    reset = 1'b1;
    // A MASK write while reset is held must not stick.
    bus_start(2'd1, 32'h0000_3F3F);
    @(negedge clk);
    @(negedge clk);
    bus.we = 1'b0;
    checks++;
    if (hwint !== none.hw || irq_any !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: hwint=%h irq_any=%b expected hwint=00 irq_any=0", hwint, irq_any);
    end
    for (int a = 0; a < 4; a++) begin
      bus.addr = 2'(a);
      #1;
      checks++;
      if (bus.rdata !== 32'h0) begin
        errors++;
        $display("FAIL reset_read%0d: rdata=%h expected 00000000", a, bus.rdata);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_level;
    int c;
    exp_t e;
    bus_write(2'd1, 32'h0000_003F);
    c = cyc;
    src = 6'h04;
    expect_hw(c + 1, 6'h00, "level_edge1");
    expect_hw(c + 2, 6'h00, "level_edge2");
    expect_hw(c + 3, 6'h04, "level_edge3");
    repeat (4) begin
      @(negedge clk);
      bus.we = 1'b0;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (hwint !== e.hw || irq_any !== (|e.hw)) begin
          errors++;
          $display("FAIL %s: hwint=%h irq_any=%b expected hwint=%h irq_any=%b",
                   e.tag, hwint, irq_any, e.hw, |e.hw);
        end
      end
    end
    bus.addr = 2'd3; #1; checks++;
    if (bus.rdata !== 32'h8000_0002) begin
      errors++; $display("FAIL level_id: rdata=%h expected 80000002", bus.rdata);
    end
    bus.addr = 2'd0; #1; checks++;
    if (bus.rdata !== 32'h0000_0004) begin
      errors++; $display("FAIL level_pend: rdata=%h expected 00000004", bus.rdata);
    end
    bus.addr = 2'd1; #1; checks++;
    if (bus.rdata !== 32'h0000_003F) begin
      errors++; $display("FAIL level_mask: rdata=%h expected 0000003f", bus.rdata);
    end
  endtask

  task automatic test_priority;
    int c;
    exp_t e;
    // Source and mask change in the same cycle; the new mask lands one edge
    // before the new source reaches s2.
    c = cyc;
    src = 6'h21;
    bus_start(2'd1, 32'h0000_0020);
    expect_hw(c + 1, 6'h04, "prio_edge1");
    expect_hw(c + 2, 6'h00, "prio_edge2");
    expect_hw(c + 3, 6'h20, "prio_edge3");
    repeat (3) begin
      @(negedge clk);
      bus.we = 1'b0;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (hwint !== e.hw || irq_any !== (|e.hw)) begin
          errors++;
          $display("FAIL %s: hwint=%h irq_any=%b expected hwint=%h irq_any=%b",
                   e.tag, hwint, irq_any, e.hw, |e.hw);
        end
      end
    end
    bus.addr = 2'd3; #1; checks++;
    if (bus.rdata !== 32'h8000_0005) begin
      errors++; $display("FAIL prio_id5: rdata=%h expected 80000005", bus.rdata);
    end
    c = cyc;
    bus_start(2'd1, 32'h0000_0021);
    expect_hw(c + 1, 6'h20, "prio_newmask1");
    expect_hw(c + 2, 6'h21, "prio_newmask2");
    repeat (2) begin
      @(negedge clk);
      bus.we = 1'b0;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (hwint !== e.hw || irq_any !== (|e.hw)) begin
          errors++;
          $display("FAIL %s: hwint=%h irq_any=%b expected hwint=%h irq_any=%b",
                   e.tag, hwint, irq_any, e.hw, |e.hw);
        end
      end
    end
    bus.addr = 2'd3; #1; checks++;
    if (bus.rdata !== 32'h8000_0000) begin
      errors++; $display("FAIL prio_id0: rdata=%h expected 80000000", bus.rdata);
    end
  endtask

  task automatic test_mask_zero;
    logic [31:0] exp_mask;
    logic [31:0] exp_pend;
    bus_write(2'd1, 32'h0000_0000);
    src = 6'h3F;
    repeat (3) @(negedge clk);
    checks++;
    if (hwint !== 6'h00 || irq_any !== 1'b0) begin
      errors++;
      $display("FAIL mask0_out: hwint=%h irq_any=%b expected hwint=00 irq_any=0", hwint, irq_any);
    end
    bus.addr = 2'd0; #1; checks++;
    if (bus.rdata !== 32'h0000_003F) begin
      errors++; $display("FAIL mask0_pend: rdata=%h expected 0000003f", bus.rdata);
    end
    bus.addr = 2'd3; #1; checks++;
    if (bus.rdata !== 32'h0000_0000) begin
      errors++; $display("FAIL mask0_id: rdata=%h expected 00000000", bus.rdata);
    end
    bus.addr = 2'd2; #1; checks++;
    if (bus.rdata !== 32'h0000_0000) begin
      errors++; $display("FAIL ack_read: rdata=%h expected 00000000", bus.rdata);
    end
    // ACK on level sources and writes to read-only words change nothing.
    bus_write(2'd2, 32'h0000_003F);
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus.addr = 2'd0; #1; checks++;
    if (bus.rdata !== 32'h0000_003F) begin
      errors++; $display("FAIL level_ack_pend: rdata=%h expected 0000003f", bus.rdata);
    end
    bus.addr = 2'd1; #1; checks++;
    if (bus.rdata !== 32'h0000_0000) begin
      errors++; $display("FAIL ro_write_mask: rdata=%h expected 00000000", bus.rdata);
    end
    // TRIG field: sources already high produce no rising edge in edge mode.
`ifdef IRQ_CTRL_EDGE_EN
    exp_mask = 32'h0000_3F3F;
    exp_pend = 32'h0000_0000;
`else
    exp_mask = 32'h0000_003F;
    exp_pend = 32'h0000_003F;
`endif
    bus_write(2'd1, 32'h0000_3F3F);
    @(negedge clk);
    bus.addr = 2'd1; #1; checks++;
    if (bus.rdata !== exp_mask) begin
      errors++; $display("FAIL trig_read: rdata=%h expected %h", bus.rdata, exp_mask);
    end
    bus.addr = 2'd0; #1; checks++;
    if (bus.rdata !== exp_pend) begin
      errors++; $display("FAIL trig_pend: rdata=%h expected %h", bus.rdata, exp_pend);
    end
    bus_write(2'd1, 32'h0000_0000);
    src = 6'h00;
    repeat (4) @(negedge clk);
  endtask

`ifdef IRQ_CTRL_EDGE_EN
  task automatic test_edge;
    int c;
    exp_t e;
    bus_write(2'd1, 32'h0000_0101);
    c = cyc;
    src = 6'h01;
    expect_hw(c + 3, 6'h00, "edge_edge3");
    expect_hw(c + 4, 6'h01, "edge_edge4");
    expect_hw(c + 6, 6'h01, "edge_held");
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      src = 6'h00;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (hwint !== e.hw || irq_any !== (|e.hw)) begin
          errors++;
          $display("FAIL %s: hwint=%h irq_any=%b expected hwint=%h irq_any=%b",
                   e.tag, hwint, irq_any, e.hw, |e.hw);
        end
      end
    end
    bus.addr = 2'd0; #1; checks++;
    if (bus.rdata !== 32'h0000_0001) begin
      errors++; $display("FAIL edge_pend: rdata=%h expected 00000001", bus.rdata);
    end
    c = cyc;
    bus_start(2'd2, 32'h0000_0001);
    expect_hw(c + 1, 6'h01, "ack_edge1");
    expect_hw(c + 2, 6'h00, "ack_edge2");
    repeat (2) begin
      @(negedge clk);
      bus.we = 1'b0;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (hwint !== e.hw || irq_any !== (|e.hw)) begin
          errors++;
          $display("FAIL %s: hwint=%h irq_any=%b expected hwint=%h irq_any=%b",
                   e.tag, hwint, irq_any, e.hw, |e.hw);
        end
      end
    end
    bus.addr = 2'd0; #1; checks++;
    if (bus.rdata !== 32'h0000_0000) begin
      errors++; $display("FAIL ack_pend: rdata=%h expected 00000000", bus.rdata);
    end
  endtask

  task automatic test_ack_collision;
    // Latch bit 0 first so a winning ACK would visibly clear it.
    src = 6'h01; @(negedge clk);
    src = 6'h00; repeat (4) @(negedge clk);
    src = 6'h01; @(negedge clk);
    src = 6'h00; @(negedge clk);
    bus_start(2'd2, 32'h0000_0001);
    @(negedge clk);
    bus.we = 1'b0;
    bus.addr = 2'd0; #1; checks++;
    if (bus.rdata !== 32'h0000_0001) begin
      errors++; $display("FAIL ack_vs_edge: rdata=%h expected 00000001", bus.rdata);
    end
    bus_write(2'd2, 32'h0000_0001);
    bus.addr = 2'd0; #1; checks++;
    if (bus.rdata !== 32'h0000_0000) begin
      errors++; $display("FAIL ack_after_collision: rdata=%h expected 00000000", bus.rdata);
    end
  endtask

  task automatic test_trig_fall;
    src = 6'h01; @(negedge clk);
    src = 6'h00; repeat (4) @(negedge clk);
    bus.addr = 2'd0; #1; checks++;
    if (bus.rdata !== 32'h0000_0001) begin
      errors++; $display("FAIL trig_fall_setup: rdata=%h expected 00000001", bus.rdata);
    end
    bus_write(2'd1, 32'h0000_0001);
    bus_write(2'd1, 32'h0000_0101);
    bus.addr = 2'd0; #1; checks++;
    if (bus.rdata !== 32'h0000_0000) begin
      errors++; $display("FAIL trig_fall_clear: rdata=%h expected 00000000", bus.rdata);
    end
  endtask
`endif

  task automatic test_reset_async;
    int c;
    exp_t e;
    bus_write(2'd1, 32'h0000_0004);
    c = cyc;
    src = 6'h04;
    expect_hw(c + 3, 6'h04, "pre_reset");
    repeat (3) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (hwint !== e.hw || irq_any !== (|e.hw)) begin
          errors++;
          $display("FAIL %s: hwint=%h irq_any=%b expected hwint=%h irq_any=%b",
                   e.tag, hwint, irq_any, e.hw, |e.hw);
        end
      end
    end
    bus.addr = 2'd1;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (hwint !== 6'h00 || irq_any !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_out: hwint=%h irq_any=%b expected hwint=00 irq_any=0", hwint, irq_any);
    end
    checks++;
    if (bus.rdata !== 32'h0000_0000) begin
      errors++; $display("FAIL async_reset_mask: rdata=%h expected 00000000", bus.rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    // src stays high: the chain refills from zero at the normal latency.
    c = cyc;
    bus_start(2'd1, 32'h0000_0004);
    expect_hw(c + 1, 6'h00, "resync_edge1");
    expect_hw(c + 2, 6'h00, "resync_edge2");
    expect_hw(c + 3, 6'h04, "resync_edge3");
    repeat (3) begin
      @(negedge clk);
      bus.we = 1'b0;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (hwint !== e.hw || irq_any !== (|e.hw)) begin
          errors++;
          $display("FAIL %s: hwint=%h irq_any=%b expected hwint=%h irq_any=%b",
                   e.tag, hwint, irq_any, e.hw, |e.hw);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    src       = 6'h00;
    bus.addr  = 2'd0;
    bus.we    = 1'b0;
    bus.wdata = 32'h0;
    test_reset();
    test_level();
    test_priority();
    test_mask_zero();
`ifdef IRQ_CTRL_EDGE_EN
    test_edge();
    test_ack_collision();
    test_trig_fall();
`endif
    test_reset_async();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
